// File: rtl/rshift_deser.sv
// Serial-in, parallel-out receiver: frames sin_bit into WIDTH-bit words on a
// start-of-frame marker and queues them in a small FIFO with valid/ready output.
module rshift_deser #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 2,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     sin_valid,
    input  logic                     sin_bit,
    input  logic                     sin_sof,
    output logic [WIDTH-1:0]         op_data,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     overrun,
    output logic                     frame_err,
    input  logic                     clr_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] op_data_q, op_data_d;
    logic             op_valid_q, op_valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic             push, push_ok, pop, full, sof_err;
    logic [WIDTH-1:0] base, shifted;
    logic [AW-1:0]    head_idx;
    logic [AW:0]      remain;

    // Word assembly: a sof always restarts from a cleared register as bit 0.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        sof_err   = 1'b0;
        base      = sin_sof ? '0 : shreg_q;
        if (MSB_FIRST) begin
            shifted = {base[WIDTH-2:0], sin_bit};
        end else begin
            shifted = {sin_bit, base[WIDTH-1:1]};
        end
        if (sin_valid) begin
            if (sin_sof) begin
                sof_err   = (state_q == SHIFT) && (bit_cnt_q != '0);
                state_d   = SHIFT;
                bit_cnt_d = CW'(1);
                shreg_d   = shifted;
            end else if (state_q == SHIFT) begin
                shreg_d = shifted;
                if (bit_cnt_q == CW'(WIDTH - 1)) begin
                    push      = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
        end
    end

    // FIFO bookkeeping; op_data is preloaded with whatever becomes head next cycle,
    // taking the word being pushed when no older entry survives the pop.
    always_comb begin
        pop      = op_valid_q && op_ready;
        full     = (cnt_q == (AW+1)'(DEPTH));
        push_ok  = push && (!full || pop);
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = shifted;
        end
        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        head_idx   = rd_ptr_d;
        cnt_d      = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        remain     = cnt_q - (AW+1)'(pop);
        op_valid_d = (cnt_d != '0);
        op_data_d  = op_data_q;
        if (cnt_d != '0) begin
            op_data_d = (remain == '0) ? shifted : mem_q[head_idx];
        end
        overrun_d   = (push && !push_ok) ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
        frame_err_d = sof_err ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            op_data_q   <= '0;
            op_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            op_data_q   <= op_data_d;
            op_valid_q  <= op_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign op_data   = op_data_q;
    assign op_valid  = op_valid_q;
    assign fifo_cnt  = cnt_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rshift_deser.sv
// Bench for rshift_deser: MSB-first and LSB-first instances share one stimulus
// stream and are compared every cycle against a queue-based framing model.
module tb_rshift_deser;

    localparam int W = 8;
    localparam int D = 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic       sin_valid, sin_bit, sin_sof, op_ready, clr_err;
    logic [7:0] op_data0, op_data1;
    logic       op_valid0, op_valid1;
    logic [1:0] fifo_cnt0, fifo_cnt1;
    logic       overrun0, overrun1, frame_err0, frame_err1;

    always #5 clk = ~clk;

    rshift_deser #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rstn(rstn), .sin_valid(sin_valid), .sin_bit(sin_bit),
        .sin_sof(sin_sof), .op_data(op_data0), .op_valid(op_valid0),
        .op_ready(op_ready), .fifo_cnt(fifo_cnt0), .overrun(overrun0),
        .frame_err(frame_err0), .clr_err(clr_err)
    );

    rshift_deser #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rstn(rstn), .sin_valid(sin_valid), .sin_bit(sin_bit),
        .sin_sof(sin_sof), .op_data(op_data1), .op_valid(op_valid1),
        .op_ready(op_ready), .fifo_cnt(fifo_cnt1), .overrun(overrun1),
        .frame_err(frame_err1), .clr_err(clr_err)
    );

    // Reference model: bits of the current frame, queued words (first bit = MSB).
    bit         m_in_frame;
    int         m_bits[$];
    logic [7:0] m_fifo[$];
    bit         m_ovr, m_ferr;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_bits.delete();
        m_fifo.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic model_edge(input bit v, input bit b, input bit s, input bit r, input bit c);
        bit         pop, done, ferr_ev;
        logic [7:0] word;
        pop     = (m_fifo.size() > 0) && r;
        done    = 1'b0;
        ferr_ev = 1'b0;
        word    = '0;
        if (v) begin
            if (s) begin
                if (m_in_frame && m_bits.size() != 0) ferr_ev = 1'b1;
                m_bits.delete();
                m_bits.push_back(int'(b));
                m_in_frame = 1'b1;
            end else if (m_in_frame) begin
                m_bits.push_back(int'(b));
                if (m_bits.size() == W) begin
                    foreach (m_bits[i]) word = 8'(word * 2 + m_bits[i]);
                    done = 1'b1;
                    m_bits.delete();
                end
            end
        end
        if (c) begin
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
        end
        if (ferr_ev) m_ferr = 1'b1;
        if (pop) void'(m_fifo.pop_front());
        if (done) begin
            if (m_fifo.size() < D) m_fifo.push_back(word);
            else m_ovr = 1'b1;
        end
    endtask

    task automatic compare_all();
        check_eq("valid_msb", op_valid0, m_fifo.size() > 0);
        check_eq("valid_lsb", op_valid1, m_fifo.size() > 0);
        check_eq("cnt_msb", fifo_cnt0, m_fifo.size());
        check_eq("cnt_lsb", fifo_cnt1, m_fifo.size());
        check_eq("ovr_msb", overrun0, m_ovr);
        check_eq("ovr_lsb", overrun1, m_ovr);
        check_eq("ferr_msb", frame_err0, m_ferr);
        check_eq("ferr_lsb", frame_err1, m_ferr);
        if (m_fifo.size() > 0) begin
            check_eq("data_msb", op_data0, m_fifo[0]);
            check_eq("data_lsb", op_data1, rev8(m_fifo[0]));
        end
    endtask

    task automatic step(input bit v, input bit b, input bit s, input bit r, input bit c);
        sin_valid = v;
        sin_bit   = b;
        sin_sof   = s;
        op_ready  = r;
        clr_err   = c;
        @(posedge clk);
        model_edge(v, b, s, r, c);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    // Transmits w[7] first; rdy_last applies only on the cycle carrying the last bit.
    task automatic send_word(input logic [7:0] w, input bit sof, input int gap,
                             input bit rdy, input bit rdy_last);
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, w[i], sof && (i == 7), (i == 0) ? rdy_last : rdy, 1'b0);
            if (i > 0) for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), 1'b0, rdy, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, {op_valid0, op_valid1}, 2'b00);
        check_eq({tag, "_data"}, {op_data0, op_data1}, 16'h0000);
        check_eq({tag, "_cnt"}, {fifo_cnt0, fifo_cnt1}, 4'h0);
        check_eq({tag, "_flags"}, {overrun0, overrun1, frame_err0, frame_err1}, 4'h0);
    endtask

    initial begin
        rstn = 1'b0;
        sin_valid = 1'b0; sin_bit = 1'b0; sin_sof = 1'b0; op_ready = 1'b0; clr_err = 1'b0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        // Bits without sof while idle are ignored
        for (int k = 0; k < 6; k++) step(1'b1, 1'($urandom), 1'b0, 1'b1, 1'b0);
        check_eq("idle_ignore", fifo_cnt0, 0);

        send_word(8'hA5, 1'b1, 0, 1'b1, 1'b1);
        check_eq("a5_valid", op_valid0, 1);
        check_eq("a5_data", op_data0, 8'hA5);
        check_eq("a5_cnt", fifo_cnt0, 1);
        idle(1, 1'b1);
        check_eq("a5_drained", fifo_cnt0, 0);

        // sof on a word boundary: no framing error
        send_word(8'hC0, 1'b1, 0, 1'b1, 1'b1);
        check_eq("c0_msb", op_data0, 8'hC0);
        check_eq("c0_lsb", op_data1, 8'h03);
        check_eq("boundary_sof_ferr", frame_err0, 0);
        idle(1, 1'b1);

        // Overrun: three words, one sof, consumer stalled
        send_word(8'h11, 1'b1, 0, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 0, 1'b0, 1'b0);
        send_word(8'h33, 1'b0, 0, 1'b0, 1'b0);
        check_eq("ovr_cnt", fifo_cnt0, 2);
        check_eq("ovr_flag", overrun0, 1);
        check_eq("drain_first", op_data0, 8'h11);
        idle(1, 1'b1);
        check_eq("drain_second", op_data0, 8'h22);
        idle(1, 1'b1);
        check_eq("drain_empty", fifo_cnt0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("ovr_cleared", overrun0, 0);

        // Framing error: sof after three bits, only the second frame survives
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_word(8'hF0, 1'b1, 0, 1'b1, 1'b1);
        check_eq("ferr_set", frame_err0, 1);
        check_eq("ferr_data", op_data0, 8'hF0);
        check_eq("ferr_cnt", fifo_cnt0, 1);
        idle(1, 1'b1);
        check_eq("ferr_only_one", fifo_cnt0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Gapped serial input
        send_word(8'h5A, 1'b1, 4, 1'b1, 1'b1);
        check_eq("gap_data", op_data0, 8'h5A);
        check_eq("gap_flags", {overrun0, frame_err0}, 2'b00);
        idle(2, 1'b1);

        // Full FIFO with a pop on the completing cycle keeps the new word
        send_word(8'h81, 1'b1, 0, 1'b0, 1'b0);
        send_word(8'h42, 1'b0, 0, 1'b0, 1'b0);
        send_word(8'h24, 1'b0, 0, 1'b0, 1'b1);
        check_eq("fullpop_cnt", fifo_cnt0, 2);
        check_eq("fullpop_ovr", overrun0, 0);
        check_eq("fullpop_head", op_data0, 8'h42);
        idle(1, 1'b1);
        check_eq("fullpop_kept", op_data0, 8'h24);
        idle(2, 1'b1);

        // Asynchronous reset with a queued word and a partial frame
        send_word(8'h77, 1'b1, 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #3 rstn = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        sin_valid = 1'b0; sin_sof = 1'b0; clr_err = 1'b0; op_ready = 1'b0;
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        send_word(8'h3C, 1'b1, 0, 1'b1, 1'b1);
        check_eq("post_rst_msb", op_data0, 8'h3C);
        check_eq("post_rst_lsb", op_data1, 8'h3C);
        idle(1, 1'b1);

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            step(($urandom % 4) != 0, 1'($urandom), ($urandom % 16) == 0,
                 ($urandom % 3) != 0, ($urandom % 32) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rshift_deser.md
Name: rshift_deser

Overview:
- Serial-in, parallel-out receiver: the far end of the rotating left-shift serializer.
- Samples one bit per qualified clock, assembles WIDTH-bit words delimited by a start-of-frame marker, and queues them in a small FIFO.
- Words leave the FIFO on a valid/ready interface.
- Flags overrun and framing errors for the control block above.

Parameters:
- WIDTH, 8, bits per assembled word (>= 2)
- DEPTH, 2, output FIFO entries (power of two, >= 2)
- MSB_FIRST, 1, 1: first serial bit lands in op_data[WIDTH-1]; 0: first bit lands in op_data[0]

Ports:
- clk  input  1  clock, all state updates on rising edge
- rstn  input  1  reset, asynchronous, active-low
- sin_valid  input  1  sin_bit/sin_sof qualified this cycle
- sin_bit  input  1  serial data bit
- sin_sof  input  1  marks the qualified bit as bit 0 of a new word
- op_data  output  WIDTH  head-of-FIFO word
- op_valid  output  1  op_data holds a valid word
- op_ready  input  1  consumer accepts op_data this cycle
- fifo_cnt  output  $clog2(DEPTH)+1  words currently queued
- overrun  output  1  sticky: a completed word was dropped because the FIFO was full
- frame_err  output  1  sticky: sin_sof arrived mid-word
- clr_err  input  1  clears overrun and frame_err

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, bit counter=0, shift register=0, FIFO empty, op_valid=0, op_data=0, fifo_cnt=0, overrun=0, frame_err=0. Reset mid-word discards the partial word and all queued words.
- FSM states: IDLE, SHIFT.
- IDLE:
  - sin_valid=1 and sin_sof=1: the bit is sampled as bit 0; counter=1; go to SHIFT.
  - Qualified bits without sin_sof are ignored.
- SHIFT, on each sin_valid=1 cycle:
  - Bit is shifted in and the counter increments.
  - MSB_FIRST=1: shift left, new bit into LSB. MSB_FIRST=0: shift right, new bit into MSB.
  - After WIDTH bits, the first bit sits in the position defined by MSB_FIRST.
- sin_valid=0: shift register and counter hold. Gaps of any length are legal.
- Word completion: the edge that samples the WIDTH-th bit writes the assembled word (including that bit) into the FIFO.
  - op_valid is visible the following cycle, i.e. latency 1 clk after the last bit is sampled.
  - Counter wraps to 0 and the FSM stays in SHIFT, so back-to-back words need no new sin_sof.
- sin_sof=1 mid-word (counter != 0 in SHIFT): partial word discarded, frame_err<=1, this bit becomes bit 0, counter=1.
- sin_sof=1 exactly on a word boundary (counter=0): normal, no error.
- FIFO:
  - Pop occurs when op_valid && op_ready.
  - Push and pop in the same cycle are both honoured at every level; fifo_cnt is unchanged.
  - Push when full with no simultaneous pop: the word is dropped, FIFO contents are untouched, overrun<=1.
  - Push when full with a simultaneous pop: the push succeeds and there is no overrun.
  - Pop when empty is impossible (op_valid=0).
- op_data: registered head entry; it holds its value while op_valid && !op_ready.
- fifo_cnt ranges 0..DEPTH.
- Error flags:
  - clr_err=1 clears both flags.
  - If an error event and clr_err coincide, the flag is set (the event wins).
  - Neither flag affects data flow.

Test Plan:
- Serial stimulus:
  - sof + bits 1,0,1,0,0,1,0,1 on consecutive cycles, op_ready=1 -> op_data=0xA5 with op_valid=1 on the cycle after the 8th bit, for one cycle, fifo_cnt 1 then 0.
  - Same bit sequence with MSB_FIRST=0 -> op_data=0xA5 reversed = 0xA5? No: use bits 1,1,0,0,0,0,0,0 -> MSB_FIRST=1 gives 0xC0, MSB_FIRST=0 gives 0x03.
- Words 0x11, 0x22, 0x33 streamed back-to-back with a single sof, op_ready=0 -> fifo_cnt=2, overrun=1 after 3rd word; draining yields 0x11 then 0x22; clr_err -> overrun=0.
- sof, 3 bits, then sof + 0xF0 bits -> frame_err=1, only 0xF0 emitted; sof asserted at a word boundary -> frame_err stays 0.
- 0x5A with sin_valid low for 4 cycles between every bit -> op_data=0x5A, no errors; bits presented while in IDLE without sof -> no output.
- Combined boundary cases:
  - FIFO full and op_ready=1 on the cycle a new word completes -> the pushed word is kept, fifo_cnt stays 2, overrun=0.
  - rstn pulsed low mid-word and asynchronously (off-edge) -> all outputs 0 immediately; the next sof frame decodes correctly.
